// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types and sizing helpers for the staged reset sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_t;

    // One counter serves all three timed phases, so it is sized for the longest of them.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// rtl/reset_sequencer_bit_sync.sv - two-flop synchronizer for a single asynchronous level
module bit_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases a bank of downstream resets one stage at a time after lock is stable
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int STAGES        = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int STABLE_CYCLES = 256,
    parameter int GAP_CYCLES    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lock_in,
    input  logic              sw_reset,
    output logic [STAGES-1:0] stage_resetn,
    output logic              done
);

    localparam int CW = cnt_width(HOLD_CYCLES, STABLE_CYCLES, GAP_CYCLES);
    localparam int IW = $clog2(STAGES) + 1;

    localparam logic [CW-1:0]     HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_LAST    = IW'(STAGES - 1);
    localparam logic [STAGES-1:0] FIRST_BIT   = STAGES'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          lock_s;

    bit_sync u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (lock_in),
        .q      (lock_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            stage_resetn <= '0;
            done         <= 1'b0;
        end else if (sw_reset || (!lock_s && (state == RELEASE || state == RUN))) begin
            // All stages drop together; a partial release is never left behind.
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            stage_resetn <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        cnt          <= '0;
                        idx          <= IW'(1);
                        stage_resetn <= stage_resetn | FIRST_BIT;
                        if (STAGES == 1) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt          <= '0;
                        idx          <= idx + 1'b1;
                        stage_resetn <= stage_resetn | (FIRST_BIT << idx);
                        if (idx == IDX_LAST) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for the staged reset sequencer
module tb_reset_sequencer;

    localparam int ST = 4;
    localparam int H  = 16;
    localparam int S  = 256;
    localparam int G  = 8;

    logic          clk = 1'b0;
    logic          resetn, lock_in, sw_reset;
    logic [ST-1:0] stage_resetn;
    logic          done;
    logic          resetn1, lock1, sw1;
    logic [0:0]    stage1;
    logic          done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .lock_in      (lock_in),
        .sw_reset     (sw_reset),
        .stage_resetn (stage_resetn),
        .done         (done)
    );

    reset_sequencer #(.STAGES(1), .GAP_CYCLES(1)) u_one (
        .clk          (clk),
        .resetn       (resetn1),
        .lock_in      (lock1),
        .sw_reset     (sw1),
        .stage_resetn (stage1),
        .done         (done1)
    );

    // Reference: edges since last restart, consecutive stable-lock count, and edges since stage 0 went out.
    int            m_age, m_since, m_stable, m_k;
    bit            m_has_rel;
    logic          m_s1, m_s2, m_ls;
    logic [ST-1:0] exp_stage;
    logic          exp_done;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_age = 0; m_since = 0; m_stable = 0; m_has_rel = 0;
            m_s1 = 0; m_s2 = 0;
        end else begin
            m_ls = m_s2; m_s2 = m_s1; m_s1 = lock_in;
            m_age++;
            if (sw_reset || (m_has_rel && !m_ls)) begin
                m_age = 0; m_since = 0; m_stable = 0; m_has_rel = 0;
            end else if (m_has_rel) begin
                m_since++;
            end else if (m_age > H) begin
                if (m_ls) begin
                    m_stable++;
                    if (m_stable == S) begin
                        m_has_rel = 1;
                        m_since   = 0;
                    end
                end else begin
                    m_stable = 0;
                end
            end
        end
        if (!m_has_rel) begin
            exp_stage = '0;
            exp_done  = 1'b0;
        end else begin
            m_k = 1 + m_since / G;
            if (m_k > ST) m_k = ST;
            exp_stage = ST'((1 << m_k) - 1);
            exp_done  = (m_k == ST);
        end
    end

    task automatic test_reset();
        resetn = 0; lock_in = 1; sw_reset = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (stage_resetn !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state stage_resetn=%b done=%b expected 0000/0", stage_resetn, done);
        end
    endtask

    task automatic test_release_timing();
        int first[ST];
        int first_done;
        int want[ST];
        want = '{271, 279, 287, 295};
        for (int i = 0; i < ST; i++) first[i] = -1;
        first_done = -1;
        resetn = 1;
        for (int e = 0; e < 300; e++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL timing_model e=%0d stage_resetn=%b done=%b expected %b/%b", e, stage_resetn, done, exp_stage, exp_done);
            end
            for (int i = 0; i < ST; i++) if (stage_resetn[i] === 1'b1 && first[i] < 0) first[i] = e;
            if (done === 1'b1 && first_done < 0) first_done = e;
        end
        for (int i = 0; i < ST; i++) begin
            checks++;
            if (first[i] != want[i]) begin
                failures++;
                $display("FAIL release_edge_bit%0d got E%0d expected E%0d", i, first[i], want[i]);
            end
        end
        checks++;
        if (first_done != 295) begin
            failures++;
            $display("FAIL done_edge got E%0d expected E295", first_done);
        end
    endtask

    task automatic test_sw_reset_run();
        int c_done;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL run_before_sw done=%b expected 1", done);
        end
        sw_reset = 1;
        @(negedge clk);
        sw_reset = 0;
        checks++;
        if (stage_resetn !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL sw_reset_next_edge stage_resetn=%b done=%b expected 0000/0", stage_resetn, done);
        end
        c_done = -1;
        for (int c = 1; c <= 400 && c_done < 0; c++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL sw_model c=%0d stage_resetn=%b done=%b expected %b/%b", c, stage_resetn, done, exp_stage, exp_done);
            end
            if (done === 1'b1) c_done = c;
        end
        checks++;
        if (c_done != H + S + 3 * G) begin
            failures++;
            $display("FAIL sw_done_latency got %0d expected %0d", c_done, H + S + 3 * G);
        end
    endtask

    task automatic test_lock_glitch_wait();
        int c_rel;
        sw_reset = 1;
        @(negedge clk);
        sw_reset = 0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL glitch_model c=%0d stage_resetn=%b done=%b expected %b/%b", c, stage_resetn, done, exp_stage, exp_done);
            end
        end
        lock_in = 0;
        @(negedge clk);
        lock_in = 1;
        c_rel = -1;
        for (int c = 101; c <= 600 && c_rel < 0; c++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL glitch_model c=%0d stage_resetn=%b done=%b expected %b/%b", c, stage_resetn, done, exp_stage, exp_done);
            end
            if (stage_resetn[0] === 1'b1) c_rel = c;
        end
        checks++;
        if (c_rel != 100 + 2 + S) begin
            failures++;
            $display("FAIL glitch_release_edge got %0d expected %0d", c_rel, 100 + 2 + S);
        end
    endtask

    task automatic test_lock_loss_release();
        bit   found;
        int   c_done;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (stage_resetn === 4'b0011) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL loss_reach_bit1 stage_resetn=%b expected 0011 within 100 cycles", stage_resetn);
        end
        lock_in = 0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (e < 3 && stage_resetn !== 4'b0011) begin
                failures++;
                $display("FAIL loss_early_edge%0d stage_resetn=%b expected 0011", e, stage_resetn);
            end
            if (e == 3 && (stage_resetn !== 4'b0000 || done !== 1'b0)) begin
                failures++;
                $display("FAIL loss_third_edge stage_resetn=%b done=%b expected 0000/0", stage_resetn, done);
            end
        end
        lock_in = 1;
        c_done = -1;
        for (int c = 1; c <= 800 && c_done < 0; c++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL loss_model c=%0d stage_resetn=%b done=%b expected %b/%b", c, stage_resetn, done, exp_stage, exp_done);
            end
            if (done === 1'b1) c_done = c;
        end
        checks++;
        if (c_done != H + S + 3 * G) begin
            failures++;
            $display("FAIL loss_done_latency got %0d expected %0d", c_done, H + S + 3 * G);
        end
    endtask

    task automatic test_async_reset();
        int c_done;
        bit found;
        sw_reset = 1;
        @(negedge clk);
        sw_reset = 0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (stage_resetn[0] === 1'b1) found = 1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stage_resetn === 4'b0000) begin
            failures++;
            $display("FAIL async_precondition stage_resetn=%b expected nonzero", stage_resetn);
        end
        #2 resetn = 0;
        #1;
        checks++;
        if (stage_resetn !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_assert stage_resetn=%b done=%b expected 0000/0", stage_resetn, done);
        end
        @(negedge clk);
        resetn = 1;
        c_done = -1;
        for (int c = 1; c <= 400 && c_done < 0; c++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL async_model c=%0d stage_resetn=%b done=%b expected %b/%b", c, stage_resetn, done, exp_stage, exp_done);
            end
            if (done === 1'b1) c_done = c;
        end
        checks++;
        if (c_done != H + S + 3 * G) begin
            failures++;
            $display("FAIL async_done_latency got %0d expected %0d", c_done, H + S + 3 * G);
        end
    endtask

    task automatic test_random();
        int drop_left;
        int sw_left;
        drop_left = 0;
        sw_left   = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            checks++;
            if (stage_resetn !== exp_stage || done !== exp_done) begin
                failures++;
                $display("FAIL random_model c=%0d stage_resetn=%b done=%b expected %b/%b", c, stage_resetn, done, exp_stage, exp_done);
            end
            if (drop_left > 0) begin
                drop_left--;
                lock_in = 0;
            end else if ($urandom_range(0, 599) == 0) begin
                drop_left = $urandom_range(0, 5);
                lock_in = 0;
            end else begin
                lock_in = 1;
            end
            if (sw_left > 0) begin
                sw_left--;
                sw_reset = 1;
            end else if ($urandom_range(0, 699) == 0) begin
                sw_left  = $urandom_range(0, 3);
                sw_reset = 1;
            end else begin
                sw_reset = 0;
            end
        end
        lock_in  = 1;
        sw_reset = 0;
    endtask

    task automatic test_single_stage();
        int c_rel;
        int c_done;
        checks++;
        if (stage1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL single_reset_state stage=%b done=%b expected 0/0", stage1, done1);
        end
        @(negedge clk);
        resetn1 = 1;
        c_rel  = -1;
        c_done = -1;
        for (int e = 0; e < 400 && c_rel < 0; e++) begin
            @(negedge clk);
            if (stage1[0] === 1'b1) c_rel = e;
            if (done1 === 1'b1) c_done = e;
        end
        checks++;
        if (c_rel != H + S - 1) begin
            failures++;
            $display("FAIL single_release_edge got E%0d expected E%0d", c_rel, H + S - 1);
        end
        checks++;
        if (c_done != H + S - 1) begin
            failures++;
            $display("FAIL single_done_edge got E%0d expected E%0d", c_done, H + S - 1);
        end
    endtask

    initial begin
        resetn1 = 0; lock1 = 1; sw1 = 0;
        test_reset();
        test_release_timing();
        test_sw_reset_run();
        test_lock_glitch_wait();
        test_lock_loss_release();
        test_async_reset();
        test_random();
        test_single_stage();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller fed by the board-level reset synchronizer. It takes the synchronized active-low reset plus a lock/ready indication (PLL locked, PCIe link up) and holds a bank of downstream reset outputs asserted. Once lock has been stable, it releases those outputs one stage at a time with a fixed gap between stages. Loss of lock or a software reset request re-asserts every stage and restarts the sequence.

## Interface
- STAGES, 4, number of staged reset outputs (1..16)
- HOLD_CYCLES, 16, minimum cycles all stages stay asserted after any (re)start (>=1)
- STABLE_CYCLES, 256, consecutive cycles synchronized lock must be high before the first release (>=1)
- GAP_CYCLES, 8, cycles between successive stage releases (>=1)
- clk  input  1  sole clock
- resetn  input  1  asynchronous, active-low reset; already synchronized for deassertion upstream
- lock_in  input  1  asynchronous lock/ready indication, active-high
- sw_reset  input  1  synchronous single-cycle software reset request, active-high
- stage_resetn  output  STAGES  active-low resets; bit 0 released first
- done  output  1  high when all stages are released (state RUN)

## Operation
- lock_in passes through a 2-flop synchronizer to produce lock_s (2-cycle latency).
- One counter cnt, sized $clog2 of the largest of HOLD_CYCLES, STABLE_CYCLES and GAP_CYCLES; a stage index idx, sized $clog2(STAGES)+1.
- While resetn is low: state=HOLD, cnt=0, idx=0, stage_resetn=all 0, done=0, synchronizer flops=0.
- HOLD:
  - cnt increments each cycle.
  - At cnt==HOLD_CYCLES-1: go to WAIT_LOCK, cnt<=0. lock_s is ignored in this state.
- WAIT_LOCK:
  - lock_s==0: cnt<=0.
  - lock_s==1 and cnt==STABLE_CYCLES-1: go to RELEASE, cnt<=0, stage_resetn[0]<=1, idx<=1.
  - Otherwise: cnt increments.
- RELEASE:
  - cnt increments.
  - At cnt==GAP_CYCLES-1: cnt<=0, stage_resetn[idx]<=1, idx increments.
  - If idx==STAGES-1 on that edge: also go to RUN and set done<=1 on the same edge.
  - If STAGES==1: WAIT_LOCK goes directly to RUN with done<=1.
- RUN: outputs are static.
- Restart conditions, evaluated in every state (sw_reset has priority over all other transitions):
  - sw_reset==1 in any state.
  - lock_s==0 in RELEASE or RUN.
- Restart action: on the next edge, state<=HOLD, cnt<=0, idx<=0, stage_resetn<=0, done<=0.
- Released stages never re-assert individually; all stages re-assert together.

## Timing
- All outputs are registered. Reset values: stage_resetn=0, done=0.
- With lock_s already high, E0 = first edge with resetn high:
  - WAIT_LOCK entered at E(HOLD_CYCLES-1).
  - stage 0 released at E(HOLD_CYCLES+STABLE_CYCLES-1).
  - stage k released GAP_CYCLES*k edges after stage 0.
  - done rises together with the last stage.
- Restart latency: stage_resetn goes to 0 one edge after sw_reset is sampled high. From a lock_in fall it is 3 edges (2 synchronizer + 1).
- A lock drop during WAIT_LOCK only clears cnt; the block does not return to HOLD.
- Asynchronous resetn assertion mid-sequence forces reset values immediately, independent of clk.
- sw_reset held high for several cycles keeps the block in HOLD with cnt=0. HOLD counting starts on the first cycle sw_reset is low.

## Structure
- Package reset_sequencer_pkg holds the state enum (HOLD, WAIT_LOCK, RELEASE, RUN) and a localparam function for the max-of-three counter width.
- One sub-module, bit_sync: a 2-flop synchronizer for lock_in with asynchronous active-low reset and reset value 0.
- The FSM, counter and output registers live in the top module.

## Test plan
- Default parameters, lock_in high throughout, resetn released at E0 -> stage_resetn 0000 until E270; bit0 at E271, bit1 at E279, bit2 at E287, bit3 and done at E295.
- lock_in pulses low for 1 cycle at E100 (during WAIT_LOCK) -> cnt restarts; stage 0 is released 256 cycles after lock_s returns high; no HOLD re-entry.
- lock_in falls after bit1 is released (during RELEASE) -> 3 edges later stage_resetn=0000, done=0, HOLD re-entered; the full sequence repeats once lock is stable again.
- sw_reset pulses in RUN -> next edge stage_resetn=0000, done=0; done returns 16+256+24 cycles after HOLD entry.
- resetn asserted asynchronously mid-RELEASE, away from a clk edge -> stage_resetn=0 and done=0 immediately; the sequence restarts on resetn release.
- STAGES=1, GAP_CYCLES=1 -> the single bit and done rise together at E(HOLD+STABLE-1).
